simmem_wresp_bank: RTL

- Write-response holding bank on the real-memory side of the simulated-memory slave; it is the responder end of the release-enable interface.
- Allocates an internal identifier (iid) per accepted write address. Stores the write response returned by the real memory in that slot.
- Returns a stored response on the AXI B channel only once the delay calculator has enabled that slot.
- Reports each released slot back to the delay calculator as a one-hot pulse.

---
 rtl/simmem_wresp_bank.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/simmem_wresp_bank.sv
// simmem_wresp_bank: holds write responses from real memory until the delay calculator enables release.
// Latency: a stored response may leave on B in the same cycle its release enable arrives (combinational select).
// Backpressure: B valid/ready stall locks the presented slot; unmatched responses stall wresp_in (ready low).
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   reserve_*                      slot allocation per accepted write address; reserve_iid_o is the slot taken
//   wresp_in_*                     response from real memory, matched to the oldest waiting slot of that id
//   release_en_onehot_i            per-slot release enable from the delay calculator
//   released_addr_onehot_o         one-hot pulse of the slot leaving on B this cycle
//   wresp_out_*                    AXI B channel
module simmem_wresp_bank #(
  parameter int unsigned Capacity  = 8,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned RespWidth = 2,
  parameter int unsigned IidWidth  = $clog2(Capacity)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reserve_valid_i,
  output logic                 reserve_ready_o,
  input  logic [IdWidth-1:0]   reserve_id_i,
  output logic [IidWidth-1:0]  reserve_iid_o,
  input  logic                 wresp_in_valid_i,
  output logic                 wresp_in_ready_o,
  input  logic [IdWidth-1:0]   wresp_in_id_i,
  input  logic [RespWidth-1:0] wresp_in_resp_i,
  input  logic [Capacity-1:0]  release_en_onehot_i,
  output logic [Capacity-1:0]  released_addr_onehot_o,
  output logic                 wresp_out_valid_o,
  input  logic                 wresp_out_ready_i,
  output logic [IdWidth-1:0]   wresp_out_id_o,
  output logic [RespWidth-1:0] wresp_out_resp_o
);

  typedef enum logic {StIdle, StLocked} state_e;

  logic [Capacity-1:0]  reserved_q, has_resp_q;
  logic [IdWidth-1:0]   id_q   [Capacity];
  logic [RespWidth-1:0] resp_q [Capacity];
  // age_q[i][j] = 1: slot i is older than slot j
  logic [Capacity-1:0]  age_q  [Capacity];
  // older[i][j] = 1: slot j is older than slot i (transpose of age_q)
  logic [Capacity-1:0]  older  [Capacity];

  state_e               state_q, state_d;
  logic [IidWidth-1:0]  lock_iid_q;

  logic [Capacity-1:0]  cand, elig;
  logic [IidWidth-1:0]  resp_tgt, sel_idx, out_idx;
  logic                 reserve_hs, wresp_in_hs, out_hs;

  always_comb begin
    for (int i = 0; i < Capacity; i++) begin
      for (int j = 0; j < Capacity; j++) begin
        older[i][j] = age_q[j][i];
      end
    end
  end

  // Reservation: lowest free slot, from registered state only
  assign reserve_ready_o = |(~reserved_q);
  always_comb begin
    reserve_iid_o = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (!reserved_q[i]) reserve_iid_o = IidWidth'(i);
    end
  end
  assign reserve_hs = reserve_valid_i && reserve_ready_o;

  // Response matching: oldest reserved slot of this id still waiting for its response
  always_comb begin
    resp_tgt = '0;
    for (int i = 0; i < Capacity; i++) begin
      cand[i] = reserved_q[i] && !has_resp_q[i] && (id_q[i] == wresp_in_id_i);
    end
    for (int i = 0; i < Capacity; i++) begin
      if (cand[i] && ((cand & older[i]) == '0)) resp_tgt = IidWidth'(i);
    end
  end
  assign wresp_in_ready_o = |cand;
  assign wresp_in_hs      = wresp_in_valid_i && wresp_in_ready_o;

  // Release eligibility; an older reserved slot with the same id blocks release (AXI same-id order)
  always_comb begin
    logic [Capacity-1:0] same_id;
    sel_idx = '0;
    same_id = '0;
    for (int i = 0; i < Capacity; i++) begin
      for (int j = 0; j < Capacity; j++) begin
        same_id[j] = (id_q[j] == id_q[i]);
      end
      elig[i] = reserved_q[i] && has_resp_q[i] && release_en_onehot_i[i] &&
                ((older[i] & reserved_q & same_id) == '0);
    end
    for (int i = 0; i < Capacity; i++) begin
      if (elig[i] && ((elig & older[i]) == '0)) sel_idx = IidWidth'(i);
    end
  end

  // Output FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lock_iid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && state_d == StLocked) lock_iid_q <= sel_idx;
    end
  end

  // Output FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if ((|elig) && !wresp_out_ready_i) state_d = StLocked;
      StLocked: if (wresp_out_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output FSM: outputs. Once locked, the presented slot cannot change until it leaves.
  always_comb begin
    wresp_out_valid_o = 1'b0;
    out_idx           = sel_idx;
    case (state_q)
      StIdle:   wresp_out_valid_o = |elig;
      StLocked: begin
        wresp_out_valid_o = 1'b1;
        out_idx           = lock_iid_q;
      end
      default: ;
    endcase
  end

  assign out_hs                 = wresp_out_valid_o && wresp_out_ready_i;
  assign wresp_out_id_o         = wresp_out_valid_o ? id_q[out_idx] : '0;
  assign wresp_out_resp_o       = wresp_out_valid_o ? resp_q[out_idx] : '0;
  assign released_addr_onehot_o = out_hs ? (Capacity'(1) << out_idx) : '0;

  // Slot state. Reserve, store and release target distinct slots; release clears are applied
  // last so a slot departing this cycle never keeps an age bit against the newly reserved one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reserved_q <= '0;
      has_resp_q <= '0;
      for (int i = 0; i < Capacity; i++) begin
        id_q[i]   <= '0;
        resp_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      if (reserve_hs) begin
        reserved_q[reserve_iid_o] <= 1'b1;
        has_resp_q[reserve_iid_o] <= 1'b0;
        id_q[reserve_iid_o]       <= reserve_id_i;
        for (int j = 0; j < Capacity; j++) begin
          if (reserved_q[j]) age_q[j][reserve_iid_o] <= 1'b1;
        end
        age_q[reserve_iid_o] <= '0;
      end
      if (wresp_in_hs) begin
        resp_q[resp_tgt]     <= wresp_in_resp_i;
        has_resp_q[resp_tgt] <= 1'b1;
      end
      if (out_hs) begin
        reserved_q[out_idx] <= 1'b0;
        has_resp_q[out_idx] <= 1'b0;
        age_q[out_idx]      <= '0;
        for (int j = 0; j < Capacity; j++) begin
          age_q[j][out_idx] <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // A response whose id was never reserved stalls forever; flag it in simulation.
  logic [10:0] stall_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (wresp_in_valid_i && !wresp_in_ready_o) begin
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 11'd1;
    end else begin
      stall_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (stall_cnt_q < 11'd1000);
  end
`endif

endmodule
